// File: rtl/pixel_cfg_pkg.sv
// Shared types and default timing for the pixel configuration sequencer.
// The timing constants are the defaults picked up by the top-level parameters.
package pixel_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } cfg_state_t;

    localparam int SETUP_CYC = 1;
    localparam int WR_CYC    = 2;
    localparam int HOLD_CYC  = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pixel_cfg_onehot.sv
// Combinational pixel address decoder: one-hot select, all-ones broadcast,
// or a range error for anything else.
module pixel_cfg_onehot #(
    parameter int N_PIX      = 180,
    parameter int ADDR_W     = 8,
    parameter int BCAST_ADDR = 255
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [N_PIX-1:0]  sel,
    output logic              range_err
);

    localparam logic [ADDR_W-1:0] BCAST = ADDR_W'(BCAST_ADDR);

    logic [N_PIX-1:0] onehot;
    logic             bcast;

    // Equality per line keeps the decode free of wide comparisons.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_PIX; i++) begin
            onehot[i] = (addr == ADDR_W'(i));
        end
    end

    assign bcast = (addr == BCAST);

    always_comb begin
        sel       = '0;
        range_err = 1'b0;
        if (bcast) begin
            sel = '1;
        end else if (|onehot) begin
            sel = onehot;
        end else begin
            range_err = 1'b1;
        end
    end

endmodule

// File: rtl/pixel_cfg_sequencer.sv
// Pixel configuration write sequencer: accepts one (addr, data) request,
// then walks SETUP -> WRITE -> HOLD driving select, data and write strobe.
module pixel_cfg_sequencer #(
    parameter int N_PIX      = 180,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 15,
    parameter int SETUP_CYC  = pixel_cfg_pkg::SETUP_CYC,
    parameter int WR_CYC     = pixel_cfg_pkg::WR_CYC,
    parameter int HOLD_CYC   = pixel_cfg_pkg::HOLD_CYC,
    parameter int BCAST_ADDR = 255
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              err_clr,
    output logic [N_PIX-1:0]  pixel_sel,
    output logic [DATA_W-1:0] pixel_wdata,
    output logic              pixel_wren,
    output logic              busy,
    output logic              addr_err
);

    import pixel_cfg_pkg::*;

    localparam int CNT_W = $clog2(max3(SETUP_CYC, WR_CYC, HOLD_CYC) + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    cfg_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [N_PIX-1:0] dec_sel;
    logic             dec_err;
    logic             accept;

    pixel_cfg_onehot #(
        .N_PIX      (N_PIX),
        .ADDR_W     (ADDR_W),
        .BCAST_ADDR (BCAST_ADDR)
    ) u_dec (
        .addr      (cfg_addr),
        .sel       (dec_sel),
        .range_err (dec_err)
    );

    assign accept = cfg_valid && cfg_ready;

    // pixel_sel / pixel_wdata double as the capture registers: they are
    // loaded on accept and held untouched until HOLD finishes.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= '0;
            cfg_ready   <= 1'b0;
            pixel_sel   <= '0;
            pixel_wdata <= '0;
            pixel_wren  <= 1'b0;
            busy        <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            // A same-cycle error set below overrides this clear.
            if (err_clr) begin
                addr_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cfg_ready <= 1'b1;
                    if (accept) begin
                        if (dec_err) begin
                            addr_err <= 1'b1;
                        end else begin
                            state       <= SETUP;
                            cnt         <= SETUP_LD;
                            cfg_ready   <= 1'b0;
                            busy        <= 1'b1;
                            pixel_sel   <= dec_sel;
                            pixel_wdata <= cfg_data;
                        end
                    end
                end

                SETUP: begin
                    if (cnt == '0) begin
                        state      <= WRITE;
                        cnt        <= WR_LD;
                        pixel_wren <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                WRITE: begin
                    if (cnt == '0) begin
                        state      <= HOLD;
                        cnt        <= HOLD_LD;
                        pixel_wren <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                HOLD: begin
                    if (cnt == '0) begin
                        state       <= IDLE;
                        cfg_ready   <= 1'b1;
                        busy        <= 1'b0;
                        pixel_sel   <= '0;
                        pixel_wdata <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    cfg_ready  <= 1'b1;
                    busy       <= 1'b0;
                    pixel_wren <= 1'b0;
                    pixel_sel  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_cfg_sequencer.sv
// Scoreboard bench for pixel_cfg_sequencer: stimulus pushes per-cycle output
// snapshots, a negedge monitor pops and compares them against the DUT.
module tb_pixel_cfg_sequencer;

    localparam int N_PIX  = 180;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 15;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [DATA_W-1:0] cfg_data = '0;
    logic              cfg_valid = 1'b0;
    logic              err_clr = 1'b0;
    logic              cfg_ready;
    logic [N_PIX-1:0]  pixel_sel;
    logic [DATA_W-1:0] pixel_wdata;
    logic              pixel_wren;
    logic              busy;
    logic              addr_err;

    pixel_cfg_sequencer #(
        .N_PIX      (N_PIX),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .SETUP_CYC  (1),
        .WR_CYC     (2),
        .HOLD_CYC   (1),
        .BCAST_ADDR (255)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .err_clr     (err_clr),
        .pixel_sel   (pixel_sel),
        .pixel_wdata (pixel_wdata),
        .pixel_wren  (pixel_wren),
        .busy        (busy),
        .addr_err    (addr_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int                cyc;
        logic [N_PIX-1:0]  sel;
        logic [DATA_W-1:0] data;
        logic              wren;
        logic              busy;
        logic              ready;
        logic              err;
    } snap_t;

    snap_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic [N_PIX-1:0] one;
    logic [N_PIX-1:0] all1;

    task automatic push(input int c, input logic [N_PIX-1:0] s, input logic [DATA_W-1:0] d,
                        input logic w, input logic b, input logic r, input logic e);
        snap_t x;
        x.cyc = c; x.sel = s; x.data = d; x.wren = w; x.busy = b; x.ready = r; x.err = e;
        q.push_back(x);
    endtask

    // Spec cycle k after an accept on edge E is observed at the negedge with cyc == E+k-1.
    task automatic expect_txn(input int e_acc, input logic [N_PIX-1:0] s,
                              input logic [DATA_W-1:0] d, input logic err);
        push(e_acc,     s,  d,  1'b0, 1'b1, 1'b0, err);
        push(e_acc + 1, s,  d,  1'b1, 1'b1, 1'b0, err);
        push(e_acc + 2, s,  d,  1'b1, 1'b1, 1'b0, err);
        push(e_acc + 3, s,  d,  1'b0, 1'b1, 1'b0, err);
        push(e_acc + 4, '0, '0, 1'b0, 1'b0, 1'b1, err);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [N_PIX-1:0] act, input logic [N_PIX-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where the IDLE cycle is visible.
    task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [N_PIX-1:0] exp_sel, input logic exp_err);
        int e_acc;
        e_acc = cyc + 1;
        cfg_addr = a; cfg_data = d; cfg_valid = 1'b1;
        expect_txn(e_acc, exp_sel, d, exp_err);
        @(negedge clock);
        cfg_valid = 1'b0;
        cfg_addr = ADDR_W'($urandom);
        cfg_data = DATA_W'($urandom);
        repeat (4) @(negedge clock);
    endtask

    task automatic send_bad(input logic [ADDR_W-1:0] a, input logic clr);
        int e_acc;
        e_acc = cyc + 1;
        cfg_addr = a; cfg_data = 15'h5A5A; cfg_valid = 1'b1; err_clr = clr;
        push(e_acc,     '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        push(e_acc + 1, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        cfg_valid = 1'b0; err_clr = 1'b0;
        @(negedge clock);
    endtask

    // Monitor: compares the snapshot scheduled for this cycle; otherwise a strobe is unexpected.
    always @(negedge clock) begin
        snap_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL snapshot_missed: expected cyc %0d, now at cyc %0d", q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            n_cmp++;
            if (pixel_sel !== e.sel || pixel_wdata !== e.data || pixel_wren !== e.wren ||
                busy !== e.busy || cfg_ready !== e.ready || addr_err !== e.err) begin
                n_bad++;
                $display("FAIL snapshot cyc=%0d got sel=%h data=%h wren=%b busy=%b rdy=%b err=%b want sel=%h data=%h wren=%b busy=%b rdy=%b err=%b",
                         cyc, pixel_sel, pixel_wdata, pixel_wren, busy, cfg_ready, addr_err,
                         e.sel, e.data, e.wren, e.busy, e.ready, e.err);
            end
        end else if (resetn) begin
            n_cmp++;
            if (pixel_wren !== 1'b0) begin
                n_bad++;
                $display("FAIL stray_strobe cyc=%0d: got wren %b, expected 0", cyc, pixel_wren);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_acc;
        one  = '0;
        one[0] = 1'b1;
        all1 = '1;

        // Reset state
        #1;
        chk1("rst_ready", cfg_ready, 1'b0);
        chk1("rst_wren", pixel_wren, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", addr_err, 1'b0);
        chkv("rst_sel", pixel_sel, '0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        push(cyc + 1, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clock);

        send(8'd5,   15'h1234, one << 5,   1'b0);
        send(8'd255, 15'h7FFF, all1,       1'b0);
        send(8'd179, 15'h0001, one << 179, 1'b0);
        send(8'd0,   15'h2AAA, one,        1'b0);
        send_bad(8'd180, 1'b0);
        send(8'd7,   15'h0555, one << 7,   1'b1);
        send_bad(8'd200, 1'b1);

        // err_clr alone clears the sticky flag
        err_clr = 1'b1;
        push(cyc + 1, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        err_clr = 1'b0;

        // Back-to-back with valid held high; inputs change while busy
        e_acc = cyc + 1;
        cfg_addr = 8'd0; cfg_data = 15'h1111; cfg_valid = 1'b1;
        expect_txn(e_acc,     one,      15'h1111, 1'b0);
        expect_txn(e_acc + 5, one << 1, 15'h2222, 1'b0);
        @(negedge clock);
        cfg_addr = 8'd1; cfg_data = 15'h2222;
        repeat (5) @(negedge clock);
        cfg_addr = 8'd3; cfg_data = 15'h3333;
        repeat (4) @(negedge clock);
        cfg_valid = 1'b0;
        push(e_acc + 10, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clock);

        // Reset pulsed during WRITE
        e_acc = cyc + 1;
        cfg_addr = 8'd9; cfg_data = 15'h0AAA; cfg_valid = 1'b1;
        push(e_acc,     one << 9, 15'h0AAA, 1'b0, 1'b1, 1'b0, 1'b0);
        push(e_acc + 1, one << 9, 15'h0AAA, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        cfg_valid = 1'b0;
        @(negedge clock);
        #1 resetn = 1'b0;
        #1;
        chk1("arst_wren", pixel_wren, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_ready", cfg_ready, 1'b0);
        chkv("arst_sel", pixel_sel, '0);
        chkv("arst_wdata", N_PIX'(pixel_wdata), '0);
        @(negedge clock);
        resetn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            push(cyc + k, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        repeat (6) @(negedge clock);

        chkv("scoreboard_drained", N_PIX'(q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
